dmem_lane_arbiter: RTL and testbench
====================================

Name: dmem_lane_arbiter

Overview:
- Shares the single-port dmem between the two issue lanes of the dual-issue pipeline.
- Lane 1 is always the older instruction in program order; lane 2 is the younger.
- Same-cycle memory ops are serialized in program order, and a stall is raised to freeze both lanes while the second access is served.
- Sits between the two XM-stage memory request paths and the dmem instance, which is clocked on ~clock.

Parameters:
- ADDR_W, 12, dmem word address width
- DATA_W, 32, dmem data width
- CNT_W, 16, width of the conflict counter

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- req_1  in  1  lane 1 memory op valid
- we_1  in  1  lane 1 store (1) / load (0)
- addr_1  in  ADDR_W  lane 1 address
- wdata_1  in  DATA_W  lane 1 store data
- req_2, we_2, addr_2, wdata_2  in  1/1/ADDR_W/DATA_W  same fields for lane 2
- stall  out  1  freeze both lanes' XM/MW advance this cycle
- rvalid_1  out  1  lane 1 load data valid
- rdata_1  out  DATA_W  lane 1 load data
- rvalid_2  out  1  lane 2 load data valid
- rdata_2  out  DATA_W  lane 2 load data
- address_dmem  out  ADDR_W  to dmem
- data  out  DATA_W  to dmem
- wren  out  1  to dmem
- q_dmem  in  DATA_W  from dmem; valid before the rising edge that ends the access cycle
- conflict_count  out  CNT_W  saturating count of serialized cycles

Behaviour:
- FSM states: IDLE, SECOND.
- Hold registers capture lane 2 fields: hwe, haddr, hwdata.
- Reset (reset=0, asynchronous):
  - state=IDLE; rvalid_1=rvalid_2=0; rdata_1=rdata_2=0; hold regs=0; conflict_count=0.
  - wren forced 0 and stall forced 0 combinationally while reset=0.
  - A reset mid-SECOND abandons the pending lane 2 access; its store is never written.
- dmem side is combinational from state and inputs:
  - IDLE: drives whichever lane is granted (see cases below).
  - SECOND: drives the hold registers.
- Cases in IDLE:
  - No request: wren=0, address_dmem=0, data=0, stall=0.
  - Only one req: drive that lane; stall=0; stay IDLE.
  - Both req, both loads, addr_1==addr_2: single access at addr_1; both rvalid next cycle with identical data; stall=0.
  - Both req, both stores, addr_1==addr_2: write wdata_2 only (younger wins); stall=0.
  - Both req, any other combination: drive lane 1; stall=1; capture lane 2 into hold; next=SECOND; conflict_count+=1, saturating at all-ones.
- SECOND:
  - Drive hold registers; stall=0; next=IDLE.
  - req/addr inputs are ignored; they still hold the same stalled ops and the pipeline advances at the end of this cycle.
- Read latency:
  - A load granted in cycle N gets rdata_x <= q_dmem at the end of N.
  - rvalid_x=1 for exactly cycle N+1, else 0.
  - rdata_x holds its last value when rvalid_x=0.
- Ordering guarantees:
  - Lane 1 store then lane 2 load to the same address: lane 2 sees the new data.
  - Lane 1 load then lane 2 store to the same address: lane 1 sees the old data.
- Stall timing:
  - stall is high only in the IDLE conflict cycle, at most 1 cycle per conflict.
  - Back-to-back conflicts produce a pattern of 1,0,1,0.
- Stores never assert rvalid.

Test Plan:
- Reset with reset=0 for 2 cycles, then release -> all outputs 0, state IDLE, conflict_count=0.
- Lane 1 only: store 0x12345678 @0x010, then lane 1 load @0x010 -> wren=1 in the store cycle, stall=0 throughout; rvalid_1=1 with rdata_1=0x12345678 one cycle after the load.
- Both req, lane 1 store 0xAAAA0001 @0x020, lane 2 load @0x020 -> stall=1 in cycle N (wren=1, address_dmem=0x020); in N+1 wren=0, stall=0; rvalid_2=1 in N+2 with rdata_2=0xAAAA0001; conflict_count=1.
- Both loads @0x030 (preloaded 0x55) -> no stall; in N+1 rvalid_1=rvalid_2=1, rdata_1=rdata_2=0x55.
- Both stores @0x040, lane 1 writes 0x1, lane 2 writes 0x2 -> single cycle with wren=1, data=0x2, stall=0; a later load @0x040 returns 0x2.
- Conflict (two loads @0x050/0x051), then reset=0 asserted during SECOND -> wren=0, rvalid_2 never asserts, state IDLE; conflict_count saturates at 0xFFFF under a forced long conflict stream.

Source files
------------

// File: rtl/dmem_lane_arbiter_if.sv
// dmem_lane_arbiter_if: lane request/response and dmem bus bundle for the lane arbiter
interface dmem_lane_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              req_1;
  logic              we_1;
  logic [ADDR_W-1:0] addr_1;
  logic [DATA_W-1:0] wdata_1;
  logic              req_2;
  logic              we_2;
  logic [ADDR_W-1:0] addr_2;
  logic [DATA_W-1:0] wdata_2;
  logic              stall;
  logic              rvalid_1;
  logic [DATA_W-1:0] rdata_1;
  logic              rvalid_2;
  logic [DATA_W-1:0] rdata_2;
  logic [ADDR_W-1:0] address_dmem;
  logic [DATA_W-1:0] data;
  logic              wren;
  logic [DATA_W-1:0] q_dmem;
  modport master (
    output req_1, we_1, addr_1, wdata_1, req_2, we_2, addr_2, wdata_2, q_dmem,
    input  stall, rvalid_1, rdata_1, rvalid_2, rdata_2, address_dmem, data, wren
  );
  modport slave (
    input  req_1, we_1, addr_1, wdata_1, req_2, we_2, addr_2, wdata_2, q_dmem,
    output stall, rvalid_1, rdata_1, rvalid_2, rdata_2, address_dmem, data, wren
  );
endinterface

// File: rtl/dmem_lane_arbiter.sv
// dmem_lane_arbiter: serializes the two issue lanes onto the single-port dmem in program order
module dmem_lane_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic             clock,
  input  logic             reset,
  dmem_lane_arbiter_if.slave bus,
  output logic [CNT_W-1:0] conflict_count
);
  typedef enum logic {IDLE, SECOND} state_t;
  state_t            state, state_nx;
  logic              hwe;
  logic [ADDR_W-1:0] haddr;
  logic [DATA_W-1:0] hwdata;
  logic              both, merge_ld, merge_st, conflict, sel_1, sel_2, ld_1, ld_2;
  assign both     = bus.req_1 & bus.req_2;
  assign merge_ld = both & ~bus.we_1 & ~bus.we_2 & (bus.addr_1 == bus.addr_2);
  assign merge_st = both & bus.we_1 & bus.we_2 & (bus.addr_1 == bus.addr_2);
  assign conflict = both & ~merge_ld & ~merge_st;
  assign sel_2    = merge_st | (bus.req_2 & ~bus.req_1);
  assign sel_1    = bus.req_1 & ~merge_st;
  // state register; reset abandons any pending second access
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  // a conflict in IDLE spends exactly one extra cycle in SECOND
  always_comb state_nx = (state == IDLE && conflict) ? SECOND : IDLE;
  // dmem drive, stall and load-grant decode; wren and stall are gated by reset
  always_comb begin
    bus.address_dmem = state == SECOND ? haddr : sel_2 ? bus.addr_2 : sel_1 ? bus.addr_1 : '0;
    bus.data = state == SECOND ? hwdata : sel_2 ? bus.wdata_2 : sel_1 ? bus.wdata_1 : '0;
    bus.wren = reset & (state == SECOND ? hwe : sel_2 ? bus.we_2 : sel_1 & bus.we_1);
    bus.stall = reset & (state == IDLE) & conflict;
    ld_1 = (state == IDLE) & bus.req_1 & ~bus.we_1;
    ld_2 = state == SECOND ? ~hwe : bus.req_2 & ~bus.we_2 & (~bus.req_1 | merge_ld);
  end
  // load return, lane 2 hold capture and saturating conflict counter
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      bus.rvalid_1   <= 1'b0;
      bus.rvalid_2   <= 1'b0;
      bus.rdata_1    <= '0;
      bus.rdata_2    <= '0;
      hwe            <= 1'b0;
      haddr          <= '0;
      hwdata         <= '0;
      conflict_count <= '0;
    end else begin
      bus.rvalid_1 <= ld_1;
      bus.rvalid_2 <= ld_2;
      if (ld_1) bus.rdata_1 <= bus.q_dmem;
      if (ld_2) bus.rdata_2 <= bus.q_dmem;
      if (bus.stall) begin
        hwe            <= bus.we_2;
        haddr          <= bus.addr_2;
        hwdata         <= bus.wdata_2;
        conflict_count <= conflict_count + CNT_W'(conflict_count != '1);
      end
    end
endmodule

// File: tb/tb_dmem_lane_arbiter.sv
// tb_dmem_lane_arbiter: directed self-checking bench with a falling-edge dmem model
module tb_dmem_lane_arbiter;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  int          errs = 0;
  int          checks = 0;
  logic [31:0] mem [0:4095];
  logic [15:0] cc;
  logic [3:0]  cc_s;
  dmem_lane_arbiter_if bus ();
  dmem_lane_arbiter_if bus_s ();
  dmem_lane_arbiter dut (.clock(clock), .reset(reset), .bus(bus.slave), .conflict_count(cc));
  dmem_lane_arbiter #(.CNT_W(4)) dut_s (.clock(clock), .reset(reset), .bus(bus_s.slave), .conflict_count(cc_s));
  assign bus_s.req_1   = bus.req_1;
  assign bus_s.we_1    = bus.we_1;
  assign bus_s.addr_1  = bus.addr_1;
  assign bus_s.wdata_1 = bus.wdata_1;
  assign bus_s.req_2   = bus.req_2;
  assign bus_s.we_2    = bus.we_2;
  assign bus_s.addr_2  = bus.addr_2;
  assign bus_s.wdata_2 = bus.wdata_2;
  assign bus_s.q_dmem  = bus.q_dmem;
  always #5 clock = ~clock;
  // dmem model clocked on ~clock: read-old-data, write on wren
  always @(negedge clock) begin
    if (bus.wren) mem[bus.address_dmem] <= bus.data;
    bus.q_dmem <= mem[bus.address_dmem];
  end
  task automatic cyc;
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic r1, input logic w1, input logic [11:0] a1, input logic [31:0] d1,
                       input logic r2, input logic w2, input logic [11:0] a2, input logic [31:0] d2);
    bus.req_1 = r1; bus.we_1 = w1; bus.addr_1 = a1; bus.wdata_1 = d1;
    bus.req_2 = r2; bus.we_2 = w2; bus.addr_2 = a2; bus.wdata_2 = d2;
  endtask
  task automatic idle_in;
    drive(0, 0, 12'h0, 32'h0, 0, 0, 12'h0, 32'h0);
  endtask
  initial begin
    idle_in();
    #2 reset = 1'b0;
    drive(1, 1, 12'h020, 32'h1, 1, 0, 12'h020, 32'h0);
    #1;
    chk("rst_wren", bus.wren, 0);
    chk("rst_stall", bus.stall, 0);
    cyc();
    cyc();
    chk("rst_rvalid_1", bus.rvalid_1, 0);
    chk("rst_rvalid_2", bus.rvalid_2, 0);
    chk("rst_rdata_1", bus.rdata_1, 0);
    chk("rst_rdata_2", bus.rdata_2, 0);
    chk("rst_count", cc, 0);
    idle_in();
    reset = 1'b1;
    #1;
    chk("idle_wren", bus.wren, 0);
    chk("idle_addr", bus.address_dmem, 0);
    chk("idle_data", bus.data, 0);
    cyc();
    drive(1, 1, 12'h010, 32'h12345678, 0, 0, 12'h0, 32'h0);
    #1;
    chk("l1_st_wren", bus.wren, 1);
    chk("l1_st_stall", bus.stall, 0);
    chk("l1_st_addr", bus.address_dmem, 32'h010);
    chk("l1_st_data", bus.data, 32'h12345678);
    cyc();
    drive(1, 0, 12'h010, 32'h0, 0, 0, 12'h0, 32'h0);
    #1;
    chk("l1_ld_wren", bus.wren, 0);
    chk("l1_ld_stall", bus.stall, 0);
    cyc();
    idle_in();
    #1;
    chk("l1_rvalid_1", bus.rvalid_1, 1);
    chk("l1_rdata_1", bus.rdata_1, 32'h12345678);
    chk("l1_rvalid_2", bus.rvalid_2, 0);
    cyc();
    chk("l1_rvalid_drop", bus.rvalid_1, 0);
    chk("l1_rdata_hold", bus.rdata_1, 32'h12345678);
    drive(1, 1, 12'h020, 32'hAAAA0001, 1, 0, 12'h020, 32'h0);
    #1;
    chk("cf_n_stall", bus.stall, 1);
    chk("cf_n_wren", bus.wren, 1);
    chk("cf_n_addr", bus.address_dmem, 32'h020);
    chk("cf_n_data", bus.data, 32'hAAAA0001);
    cyc();
    #1;
    chk("cf_n1_stall", bus.stall, 0);
    chk("cf_n1_wren", bus.wren, 0);
    chk("cf_n1_addr", bus.address_dmem, 32'h020);
    chk("cf_n1_count", cc, 1);
    cyc();
    idle_in();
    #1;
    chk("cf_n2_rvalid_2", bus.rvalid_2, 1);
    chk("cf_n2_rdata_2", bus.rdata_2, 32'hAAAA0001);
    chk("cf_n2_rvalid_1", bus.rvalid_1, 0);
    cyc();
    drive(1, 1, 12'h030, 32'h55, 0, 0, 12'h0, 32'h0);
    cyc();
    drive(1, 0, 12'h030, 32'h0, 1, 0, 12'h030, 32'h0);
    #1;
    chk("ml_stall", bus.stall, 0);
    chk("ml_wren", bus.wren, 0);
    chk("ml_addr", bus.address_dmem, 32'h030);
    cyc();
    idle_in();
    #1;
    chk("ml_rvalid_1", bus.rvalid_1, 1);
    chk("ml_rvalid_2", bus.rvalid_2, 1);
    chk("ml_rdata_1", bus.rdata_1, 32'h55);
    chk("ml_rdata_2", bus.rdata_2, 32'h55);
    cyc();
    drive(1, 1, 12'h040, 32'h1, 1, 1, 12'h040, 32'h2);
    #1;
    chk("ms_wren", bus.wren, 1);
    chk("ms_data", bus.data, 32'h2);
    chk("ms_stall", bus.stall, 0);
    cyc();
    drive(1, 0, 12'h040, 32'h0, 0, 0, 12'h0, 32'h0);
    cyc();
    idle_in();
    #1;
    chk("ms_readback", bus.rdata_1, 32'h2);
    chk("ms_count", cc, 1);
    cyc();
    drive(1, 1, 12'h061, 32'h61, 0, 0, 12'h0, 32'h0);
    cyc();
    drive(1, 0, 12'h050, 32'h0, 1, 0, 12'h051, 32'h0);
    #1;
    chk("ab_stall", bus.stall, 1);
    chk("ab_addr_n", bus.address_dmem, 32'h050);
    cyc();
    #1;
    chk("ab_addr_n1", bus.address_dmem, 32'h051);
    chk("ab_count", cc, 2);
    reset = 1'b0;
    #1;
    chk("ab_rst_wren", bus.wren, 0);
    chk("ab_rst_stall", bus.stall, 0);
    chk("ab_rst_rvalid_1", bus.rvalid_1, 0);
    cyc();
    idle_in();
    reset = 1'b1;
    #1;
    chk("ab_no_rvalid_2", bus.rvalid_2, 0);
    chk("ab_count_clr", cc, 0);
    cyc();
    drive(1, 0, 12'h060, 32'h0, 1, 1, 12'h061, 32'hDEAD);
    #1;
    chk("ab_st_stall", bus.stall, 1);
    cyc();
    reset = 1'b0;
    #1;
    chk("ab_st_wren", bus.wren, 0);
    cyc();
    reset = 1'b1;
    drive(1, 0, 12'h061, 32'h0, 0, 0, 12'h0, 32'h0);
    #1;
    chk("ab_st_idle", bus.stall, 0);
    cyc();
    idle_in();
    #1;
    chk("ab_st_rvalid", bus.rvalid_1, 1);
    chk("ab_st_unwritten", bus.rdata_1, 32'h61);
    cyc();
    drive(1, 0, 12'h000, 32'h0, 1, 0, 12'h001, 32'h0);
    for (int i = 0; i < 40; i++) begin
      #1;
      chk($sformatf("b2b_stall_%0d", i), bus.stall, (i % 2 == 0) ? 32'h1 : 32'h0);
      cyc();
    end
    chk("b2b_count", cc, 20);
    chk("sat_count", cc_s, 32'hF);
    idle_in();
    cyc();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
